// File: rtl/gf_mix_column_pipe.sv
// rtl/gf_mix_column_pipe.sv - two-stage AES MixColumns/InvMixColumns over LANES columns
module gf_mix_column_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [32*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_mode,
    output logic [32*LANES-1:0]   out_data,
    output logic [CNT_W-1:0]      out_cnt
);
    localparam int DW = 32 * LANES;
    localparam int NB = 4 * LANES;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Circulant matrix entry for input row i feeding output row j.
    function automatic logic [3:0] coef(input logic mode, input int i, input int j);
        logic [1:0] d;
        d = 2'(i - j);
        if (mode) begin
            case (d)
                2'd0:    return 4'hE;
                2'd1:    return 4'hB;
                2'd2:    return 4'hD;
                default: return 4'h9;
            endcase
        end else begin
            case (d)
                2'd0:    return 4'h2;
                2'd1:    return 4'h3;
                default: return 4'h1;
            endcase
        end
    endfunction

    // Product from the pre-registered xtime chain; only the seven AES coefficients occur.
    function automatic logic [7:0] gmul(input logic [3:0] c, input logic [7:0] a,
                                        input logic [7:0] x2, input logic [7:0] x4,
                                        input logic [7:0] x8);
        case (c)
            4'h1:    return a;
            4'h2:    return x2;
            4'h3:    return x2 ^ a;
            4'h9:    return x8 ^ a;
            4'hB:    return x8 ^ x2 ^ a;
            4'hD:    return x8 ^ x4 ^ a;
            4'hE:    return x8 ^ x4 ^ x2;
            default: return 8'h00;
        endcase
    endfunction

    logic          s1_v, s2_v;
    logic          s1_mode, s2_mode;
    logic [DW-1:0] s1_a, s1_x2, s1_x4, s1_x8;
    logic [DW-1:0] s2_data;
    logic [DW-1:0] nx2, nx4, nx8;
    logic [DW-1:0] mixed;
    logic          en1, en2;

    assign en2      = !s2_v || out_ready;
    assign en1      = !s1_v || en2;
    assign in_ready = en1 && !flush;

    assign out_valid = s2_v;
    assign out_mode  = s2_mode;
    assign out_data  = s2_data;

    // xtime chain per input byte: x2, x4, x8.
    always_comb begin
        nx2 = '0;
        nx4 = '0;
        nx8 = '0;
        for (int i = 0; i < NB; i++) begin
            nx2[8*i +: 8] = xtime(in_data[8*i +: 8]);
            nx4[8*i +: 8] = xtime(nx2[8*i +: 8]);
            nx8[8*i +: 8] = xtime(nx4[8*i +: 8]);
        end
    end

    // XOR combine of the stage-1 products, matrix chosen by the beat's mode.
    always_comb begin
        mixed = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < 4; j++) begin
                for (int i = 0; i < 4; i++) begin
                    mixed[32*k + 8*(3-j) +: 8] = mixed[32*k + 8*(3-j) +: 8] ^
                        gmul(coef(s1_mode, i, j),
                             s1_a [32*k + 8*(3-i) +: 8],
                             s1_x2[32*k + 8*(3-i) +: 8],
                             s1_x4[32*k + 8*(3-i) +: 8],
                             s1_x8[32*k + 8*(3-i) +: 8]);
                end
            end
        end
    end

    // Valid bits advance along the ready chain; flush empties both stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else if (flush) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            if (en1) s1_v <= in_valid;
            if (en2) s2_v <= s1_v;
        end
    end

    // Stage 1 data: operand bytes and their xtime multiples, loaded only with a real beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_mode <= 1'b0;
            s1_a    <= '0;
            s1_x2   <= '0;
            s1_x4   <= '0;
            s1_x8   <= '0;
        end else if (!flush && en1 && in_valid) begin
            s1_mode <= in_mode;
            s1_a    <= in_data;
            s1_x2   <= nx2;
            s1_x4   <= nx4;
            s1_x8   <= nx8;
        end
    end

    // Stage 2 data: mixed column result, held while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_mode <= 1'b0;
            s2_data <= '0;
        end else if (!flush && en2 && s1_v) begin
            s2_mode <= s1_mode;
            s2_data <= mixed;
        end
    end

    // Output handshake counter, wraps naturally; left alone in a flush cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt <= '0;
        end else if (!flush && s2_v && out_ready) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_gf_mix_column_pipe.sv
// tb/tb_gf_mix_column_pipe.sv - directed and random checks of gf_mix_column_pipe
module tb_gf_mix_column_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // single-lane instance with a 4-bit counter
    logic        a_flush, a_in_valid, a_in_ready, a_in_mode;
    logic        a_out_valid, a_out_ready, a_out_mode;
    logic [31:0] a_in_data, a_out_data;
    logic [3:0]  a_out_cnt;
    logic [3:0]  a_exp_cnt;

    // four-lane instance with a 16-bit counter
    logic         b_flush, b_in_valid, b_in_ready, b_in_mode;
    logic         b_out_valid, b_out_ready, b_out_mode;
    logic [127:0] b_in_data, b_out_data;
    logic [15:0]  b_out_cnt;

    gf_mix_column_pipe #(.LANES(1), .CNT_W(4)) u_one (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_mode(a_out_mode),
        .out_data(a_out_data), .out_cnt(a_out_cnt)
    );

    gf_mix_column_pipe #(.LANES(4), .CNT_W(16)) u_four (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_mode(b_out_mode),
        .out_data(b_out_data), .out_cnt(b_out_cnt)
    );

    function automatic logic [7:0] ref_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] ref_col(input logic [31:0] c, input logic m);
        logic [7:0]  a [4];
        logic [7:0]  k [4];
        logic [7:0]  y;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        if (m) begin
            k[0] = 8'h0E; k[1] = 8'h0B; k[2] = 8'h0D; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        r = '0;
        for (int j = 0; j < 4; j++) begin
            y = 8'h00;
            for (int i = 0; i < 4; i++) y = y ^ ref_gmul(a[i], k[(i - j + 4) % 4]);
            r[31-8*j -: 8] = y;
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_beat(input logic [127:0] d, input logic m);
        logic [127:0] r;
        for (int k = 0; k < 4; k++) r[32*k +: 32] = ref_col(d[32*k +: 32], m);
        return r;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        a_flush = 0; a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 0;
        b_flush = 0; b_in_valid = 0; b_in_mode = 0; b_in_data = '0; b_out_ready = 0;
        a_exp_cnt = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", a_out_data); end
        checks++; if (a_out_cnt !== 4'h0) begin errors++; $display("FAIL reset_a_cnt: got %h expected 0", a_out_cnt); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %b expected 1", a_in_ready); end
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_valid: got %b expected 0", b_out_valid); end
        checks++; if (b_out_cnt !== 16'h0) begin errors++; $display("FAIL reset_b_cnt: got %h expected 0", b_out_cnt); end
    endtask

    task automatic test_vec(input string name, input logic [31:0] din, input logic m, input logic [31:0] exp);
        @(negedge clk);
        a_in_valid = 1'b1; a_in_mode = m; a_in_data = din; a_out_ready = 1'b1;
        @(negedge clk);
        a_in_valid = 1'b0; a_in_data = '0;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL %s_early: out_valid %b expected 0", name, a_out_valid); end
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", name, a_out_valid); end
        checks++; if (a_out_data !== exp) begin errors++; $display("FAIL %s_data: got %h expected %h", name, a_out_data, exp); end
        checks++; if (a_out_mode !== m) begin errors++; $display("FAIL %s_mode: got %b expected %b", name, a_out_mode, m); end
        @(negedge clk);
        a_exp_cnt = a_exp_cnt + 4'd1;
        checks++; if (a_out_cnt !== a_exp_cnt) begin errors++; $display("FAIL %s_cnt: got %h expected %h", name, a_out_cnt, a_exp_cnt); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain: out_valid %b expected 0", name, a_out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] din [3];
        logic        md  [3];
        logic [31:0] exp [3];
        din[0] = 32'hdb135345; md[0] = 0; exp[0] = 32'h8e4da1bc;
        din[1] = 32'h8e4da1bc; md[1] = 1; exp[1] = 32'hdb135345;
        din[2] = 32'hae000000; md[2] = 1; exp[2] = 32'hcea927ee;
        a_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 5) begin
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== exp[c-2] || a_out_mode !== md[c-2])
                    begin errors++; $display("FAIL b2b_beat%0d: got v=%b m=%b %h expected v=1 m=%b %h", c-2, a_out_valid, a_out_mode, a_out_data, md[c-2], exp[c-2]); end
            end
            if (c == 5) begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail: out_valid %b expected 0", a_out_valid); end
            end
            if (c < 3) begin
                a_in_valid = 1'b1; a_in_mode = md[c]; a_in_data = din[c];
            end else begin
                a_in_valid = 1'b0;
            end
        end
        a_exp_cnt = a_exp_cnt + 4'd3;
        checks++; if (a_out_cnt !== a_exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %h expected %h", a_out_cnt, a_exp_cnt); end
    endtask

    task automatic test_flush;
        @(negedge clk);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 1'b0; a_in_data = 32'hdb135345;
        @(negedge clk);
        a_in_data = 32'hf20a225c;
        @(negedge clk);
        a_in_data = 32'hc6c6c6c6;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready: got %b expected 0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h8e4da1bc) begin errors++; $display("FAIL flush_stall_head: got v=%b %h expected v=1 8e4da1bc", a_out_valid, a_out_data); end
        @(negedge clk);
        checks++; if (a_out_data !== 32'h8e4da1bc) begin errors++; $display("FAIL flush_stall_hold: got %h expected 8e4da1bc", a_out_data); end
        a_flush = 1'b1;
        @(negedge clk);
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_out_cnt !== a_exp_cnt) begin errors++; $display("FAIL flush_cnt: got %h expected %h", a_out_cnt, a_exp_cnt); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost: out_valid %b expected 0", a_out_valid); end
        end
        // flush on an empty pipe must refuse the offered beat
        a_flush = 1'b1; a_in_valid = 1'b1; a_in_data = 32'h01020304;
        #1;
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", a_in_ready); end
        @(negedge clk);
        a_flush = 1'b0; a_in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_refused: out_valid %b expected 0", a_out_valid); end
        end
        checks++; if (a_out_cnt !== a_exp_cnt) begin errors++; $display("FAIL flush_cnt_after: got %h expected %h", a_out_cnt, a_exp_cnt); end
    endtask

    task automatic stream_a(input int n);
        @(negedge clk);
        a_out_ready = 1'b1; a_in_mode = 1'b0; a_in_data = 32'hdb135345;
        for (int i = 0; i < n; i++) begin
            a_in_valid = 1'b1;
            @(negedge clk);
        end
        a_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        a_exp_cnt = a_exp_cnt + 4'(n);
    endtask

    task automatic test_wrap;
        stream_a(15 - int'(a_exp_cnt));
        checks++; if (a_out_cnt !== 4'hF) begin errors++; $display("FAIL wrap_full: got %h expected f", a_out_cnt); end
        stream_a(1);
        checks++; if (a_out_cnt !== 4'h0) begin errors++; $display("FAIL wrap_zero: got %h expected 0", a_out_cnt); end
    endtask

    task automatic test_random;
        logic [128:0] sb [$];
        logic [128:0] e;
        int  sent, got, occ, cyc;
        logic acc, emit;
        sent = 0; got = 0; occ = 0; cyc = 0;
        while (got < 100 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            b_in_mode   = sent[0];
            b_in_data   = {$urandom, $urandom, $urandom, $urandom};
            #1;
            checks++; if (b_in_ready !== ((occ < 2) || b_out_ready)) begin errors++; $display("FAIL rand_ready: got %b expected %b occ=%0d", b_in_ready, ((occ < 2) || b_out_ready), occ); end
            acc  = b_in_valid & b_in_ready;
            emit = b_out_valid & b_out_ready;
            if (emit) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rand_extra: got unexpected beat %h expected none", b_out_data);
                end else begin
                    e = sb.pop_front();
                    if ({b_out_mode, b_out_data} !== e) begin errors++; $display("FAIL rand_beat%0d: got %h expected %h", got, {b_out_mode, b_out_data}, e); end
                end
                got++;
            end
            if (acc) begin
                sb.push_back({b_in_mode, ref_beat(b_in_data, b_in_mode)});
                sent++;
            end
            occ = occ + int'(acc) - int'(emit);
        end
        @(negedge clk);
        b_in_valid = 1'b0; b_out_ready = 1'b0;
        checks++; if (got !== 100) begin errors++; $display("FAIL rand_count: got %0d expected 100", got); end
        checks++; if (b_out_cnt !== 16'd100) begin errors++; $display("FAIL rand_cnt: got %0d expected 100", b_out_cnt); end
    endtask

    task automatic test_roundtrip;
        logic [127:0] x, y;
        b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_data = x;
            @(negedge clk);
            b_in_valid = 1'b0;
            @(negedge clk);
            y = b_out_data;
            b_in_valid = 1'b1; b_in_mode = 1'b1; b_in_data = y;
            @(negedge clk);
            b_in_valid = 1'b0;
            @(negedge clk);
            checks++; if (b_out_valid !== 1'b1 || b_out_data !== x) begin errors++; $display("FAIL roundtrip%0d: got v=%b %h expected v=1 %h", i, b_out_valid, b_out_data, x); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        stream_a(2);
        @(negedge clk);
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 1'b1; a_in_data = 32'h8e4da1bc;
        @(negedge clk);
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1 || a_out_mode !== 1'b1 || a_out_data !== 32'hdb135345)
            begin errors++; $display("FAIL rstmid_pre: got v=%b m=%b %h expected v=1 m=1 db135345", a_out_valid, a_out_mode, a_out_data); end
        #2 rst = 1'b1;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", a_out_valid); end
        checks++; if (a_out_mode !== 1'b0) begin errors++; $display("FAIL rstmid_mode: got %b expected 0", a_out_mode); end
        checks++; if (a_out_data !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 0", a_out_data); end
        checks++; if (a_out_cnt !== 4'h0) begin errors++; $display("FAIL rstmid_cnt: got %h expected 0", a_out_cnt); end
        checks++; if (b_out_cnt !== 16'h0) begin errors++; $display("FAIL rstmid_b_cnt: got %h expected 0", b_out_cnt); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", a_in_ready); end
        repeat (2) @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: out_valid %b expected 0", a_out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_vec("enc_db", 32'hdb135345, 1'b0, 32'h8e4da1bc);
        test_vec("dec_8e", 32'h8e4da1bc, 1'b1, 32'hdb135345);
        test_vec("enc_f2", 32'hf20a225c, 1'b0, 32'h9fdc589d);
        test_vec("enc_c6", 32'hc6c6c6c6, 1'b0, 32'hc6c6c6c6);
        test_vec("dec_c6", 32'hc6c6c6c6, 1'b1, 32'hc6c6c6c6);
        test_vec("dec_ae", 32'hae000000, 1'b1, 32'hcea927ee);
        test_back_to_back();
        test_flush();
        test_wrap();
        test_random();
        test_roundtrip();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
